sort_scheduler: RTL and testbench
=================================

SORT_SCHEDULER -- requirements
Module: sort_scheduler

Interface
REQ-001 Parameter: SORT_LAT, default 1, cycles the external sorter needs between a stable srt_in and a valid srt_out (range 1..15).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  2  req[r]=1: requester r wants a 9-element sort job.
REQ-005 grant  output  2  one-hot owner of the sorter, 0 when idle.
REQ-006 in_valid  input  2  element offered by requester r.
REQ-007 in_data0 / in_data1  input  4 each  element from requester 0 / 1.
REQ-008 in_ready  output  2  element accepted from requester r when in_valid[r]&in_ready[r].
REQ-009 srt_in  output  36  to sorter; element k at bits [4k+3:4k].
REQ-010 srt_out  input  36  from sorter, ascending; element k at bits [4k+3:4k].
REQ-011 out_valid  output  1  result element available.
REQ-012 out_ready  input  1  consumer accepts when out_valid&out_ready.
REQ-013 out_data  output  4  result element.
REQ-014 out_id  output  1  requester index that owns the result.
REQ-015 out_last  output  1  marks element 8 of a result.
REQ-016 busy  output  1  1 in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, PROCESS, WRITE; the only transitions are IDLE->LOAD, LOAD->PROCESS, LOAD->IDLE (abort), PROCESS->WRITE, WRITE->IDLE.
REQ-018 IDLE: if any req bit is set, next cycle SHALL enter LOAD with grant set; with both set, grant goes to the requester not served last (round-robin); single request granted directly.
REQ-019 Round-robin pointer SHALL update only when a job completes WRITE; an aborted job does not update it.
REQ-020 LOAD: in_ready[g]=1 for the granted g only, other bit 0; other requester's in_valid/data ignored.
REQ-021 LOAD: each accepted element stored at buffer index = element count (0..8); count increments per handshake, holds on in_valid=0.
REQ-022 The 9th handshake SHALL move to PROCESS on the next edge; in_ready drops in that same next cycle.
REQ-023 LOAD abort: req[g]=0 while in LOAD SHALL return to IDLE next cycle, clear count and grant, produce no output; handshake in that same cycle is discarded.
REQ-024 srt_in SHALL always be driven from the registered buffer; stable during PROCESS.
REQ-025 PROCESS: wait counter runs SORT_LAT cycles; on the last, srt_out captured into result register and FSM enters WRITE.
REQ-026 req changes during PROCESS/WRITE SHALL be ignored; grant held until WRITE ends.
REQ-027 WRITE: out_valid=1, out_data=result[idx], out_id=granted index, out_last=(idx==8); idx starts 0, advances on handshake.
REQ-028 out_ready=0 SHALL stall with out_data/out_last/out_id held constant.
REQ-029 Handshake with out_last=1 SHALL return to IDLE next cycle; out_valid=0, grant=0 that cycle; a new job may be granted from that IDLE cycle (minimum 1 idle cycle between jobs).
REQ-030 Minimum job latency, IDLE with req to first out_valid: 1 + 9 + SORT_LAT cycles with continuous in_valid.

Reset
REQ-031 rst=1 SHALL force, at the next edge regardless of state: IDLE, grant=0, in_ready=0, out_valid=0, out_data=0, out_id=0, out_last=0, busy=0, srt_in=0, counts cleared, round-robin pointer set so requester 0 wins the first contention.
REQ-032 rst asserted mid-LOAD, mid-PROCESS or mid-WRITE SHALL discard the job without emitting further elements.

Verification
REQ-033 Single job: req=01, stream 9,3,7,0,15,1,8,2,4 with continuous valid, out_ready=1 -> outputs 0,1,2,3,4,7,8,9,15, out_id=0, out_last on 15, first out_valid 11 cycles after req (SORT_LAT=1).
REQ-034 Contention: req=11 from reset -> requester 0 served first, then requester 1 without re-request gaps beyond 1 idle cycle; repeat -> order 0,1,0,1.
REQ-035 Backpressure: toggle out_ready 1/0 every cycle in WRITE -> out_data held while stalled, all 9 elements in order, exactly one out_last.
REQ-036 Abort: requester 1 drops req after 4 elements -> IDLE next cycle, no out_valid, pending requester 0 then granted and its sort correct.
REQ-037 Reset mid-WRITE at idx=5 -> next cycle all outputs zero, busy=0; new job afterwards correct.
REQ-038 SORT_LAT=3 with in_valid gaps (valid every other cycle) -> result captured after 3 PROCESS cycles, ungranted in_valid ignored, correct sorted output.

Source files
------------

// File: rtl/sort_scheduler.sv
// Two-requester front end for an external 9-element sorter: arbitrates the sorter,
// gathers a job into a buffer, waits out the sorter latency, then streams the result.

module sort_scheduler_slot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_en,
  input  logic [W-1:0] ld_data,
  input  logic         cap_en,
  input  logic [W-1:0] cap_data,
  output logic [W-1:0] buf_q,
  output logic [W-1:0] res_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      res_q <= '0;
    end else begin
      if (ld_en)  buf_q <= ld_data;
      if (cap_en) res_q <= cap_data;
    end
  end
endmodule

module sort_scheduler #(
  parameter int SORT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  grant,
  input  logic [1:0]  in_valid,
  input  logic [3:0]  in_data0,
  input  logic [3:0]  in_data1,
  output logic [1:0]  in_ready,
  output logic [35:0] srt_in,
  input  logic [35:0] srt_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic        out_id,
  output logic        out_last,
  output logic        busy
);
  localparam int NUM_ELEMS = 9;
  localparam int ELEM_W    = 4;
  localparam int CW        = 4;

  typedef enum logic [1:0] {IDLE, LOAD, PROCESS, WRITE} state_t;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic              id;
    logic [ELEM_W-1:0] data;
  } beat_t;

  state_t state, state_nxt;
  logic [1:0]    grant_q;
  logic          rr_ptr;     // requester that wins the next contention
  logic [CW-1:0] cnt, wait_cnt, idx;
  logic          gid, pick;
  logic          sel_req, sel_valid;
  logic [ELEM_W-1:0] sel_data;
  logic          abort, load_fire, load_done, proc_done, out_fire, job_done;
  logic [NUM_ELEMS-1:0]             ld_en;
  logic [NUM_ELEMS-1:0][ELEM_W-1:0] buf_q, res_q;
  beat_t         beat;

  assign gid       = grant_q[1];
  assign pick      = (req == 2'b11) ? rr_ptr : req[1];
  assign sel_req   = req[gid];
  assign sel_valid = in_valid[gid];
  assign sel_data  = gid ? in_data1 : in_data0;

  // Dropping the request wins over a same-cycle handshake.
  assign abort     = (state == LOAD) && !sel_req;
  assign load_fire = (state == LOAD) && sel_req && sel_valid;
  assign load_done = load_fire && (cnt == CW'(NUM_ELEMS-1));
  assign proc_done = (state == PROCESS) && (wait_cnt == CW'(SORT_LAT-1));
  assign out_fire  = (state == WRITE) && out_ready;
  assign job_done  = out_fire && (idx == CW'(NUM_ELEMS-1));

  for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_slot
    assign ld_en[k] = load_fire && (cnt == CW'(k));
    sort_scheduler_slot #(.W(ELEM_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .ld_en    (ld_en[k]),
      .ld_data  (sel_data),
      .cap_en   (proc_done),
      .cap_data (srt_out[ELEM_W*k +: ELEM_W]),
      .buf_q    (buf_q[k]),
      .res_q    (res_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = LOAD;
      LOAD: begin
        if (abort)          state_nxt = IDLE;
        else if (load_done) state_nxt = PROCESS;
      end
      PROCESS: if (proc_done) state_nxt = WRITE;
      WRITE:   if (job_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    beat     = '0;
    in_ready = 2'b00;
    if (state == LOAD) in_ready = grant_q;
    if (state == WRITE) begin
      beat.valid = 1'b1;
      beat.last  = (idx == CW'(NUM_ELEMS-1));
      beat.id    = gid;
      beat.data  = res_q[idx];
    end
  end

  assign out_valid = beat.valid;
  assign out_last  = beat.last;
  assign out_id    = beat.id;
  assign out_data  = beat.data;
  assign grant     = grant_q;
  assign busy      = (state != IDLE);
  assign srt_in    = buf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= '0;
      rr_ptr   <= 1'b0;
      cnt      <= '0;
      wait_cnt <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: if (|req) grant_q <= pick ? 2'b10 : 2'b01;
        LOAD: begin
          if (abort) grant_q <= '0;
          if (abort || load_done) cnt <= '0;
          else if (load_fire)     cnt <= cnt + 1'b1;
        end
        PROCESS: wait_cnt <= proc_done ? '0 : wait_cnt + 1'b1;
        WRITE: begin
          if (out_fire) begin
            if (job_done) begin
              idx     <= '0;
              grant_q <= '0;
              rr_ptr  <= ~gid;  // the other requester gets priority next time
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_scheduler.sv
// Directed bench: two instances (sorter latency 1 and 3) share stimulus; one is held
// in reset while the other is exercised. Sorter is modelled with SORT_LAT-1 stages.
module tb_sort_scheduler;
  logic        clk;
  logic        rst1, rst3;
  logic [1:0]  req, in_valid;
  logic [3:0]  in_data0, in_data1;
  logic        out_ready;
  logic        sel;

  logic [1:0]  grant1, grant3, in_ready1, in_ready3;
  logic [35:0] srt_in1, srt_in3, srt_out1, srt_out3, dly_a, dly_b;
  logic        out_valid1, out_valid3, out_id1, out_id3, out_last1, out_last3, busy1, busy3;
  logic [3:0]  out_data1, out_data3;

  logic [1:0]  o_grant, o_in_ready;
  logic [35:0] o_srt_in;
  logic        o_valid, o_id, o_last, o_busy;
  logic [3:0]  o_data;

  int checks, errors, cyc, n, t0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [35:0] sort9(input logic [35:0] v);
    logic [3:0] a [9];
    logic [3:0] t;
    logic [35:0] r;
    for (int i = 0; i < 9; i++) a[i] = v[4*i +: 4];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < 9; i++) r[4*i +: 4] = a[i];
    return r;
  endfunction

  assign srt_out1 = sort9(srt_in1);
  always @(posedge clk) begin
    dly_a <= srt_in3;
    dly_b <= dly_a;
  end
  assign srt_out3 = sort9(dly_b);

  sort_scheduler #(.SORT_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .req(req), .grant(grant1), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_ready(in_ready1),
    .srt_in(srt_in1), .srt_out(srt_out1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_id(out_id1), .out_last(out_last1), .busy(busy1));

  sort_scheduler #(.SORT_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req(req), .grant(grant3), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_ready(in_ready3),
    .srt_in(srt_in3), .srt_out(srt_out3), .out_valid(out_valid3), .out_ready(out_ready),
    .out_data(out_data3), .out_id(out_id3), .out_last(out_last3), .busy(busy3));

  assign o_grant    = sel ? grant3     : grant1;
  assign o_in_ready = sel ? in_ready3  : in_ready1;
  assign o_srt_in   = sel ? srt_in3    : srt_in1;
  assign o_valid    = sel ? out_valid3 : out_valid1;
  assign o_data     = sel ? out_data3  : out_data1;
  assign o_id       = sel ? out_id3    : out_id1;
  assign o_last     = sel ? out_last3  : out_last1;
  assign o_busy     = sel ? busy3      : busy1;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_grant"},     36'(o_grant),    36'd0);
    chk({t, "_in_ready"},  36'(o_in_ready), 36'd0);
    chk({t, "_out_valid"}, 36'(o_valid),    36'd0);
    chk({t, "_out_data"},  36'(o_data),     36'd0);
    chk({t, "_out_id"},    36'(o_id),       36'd0);
    chk({t, "_out_last"},  36'(o_last),     36'd0);
    chk({t, "_busy"},      36'(o_busy),     36'd0);
    chk({t, "_srt_in"},    o_srt_in,        36'd0);
  endtask

  // Starts at posedge+1 of a LOAD cycle; ends at posedge+1 after the n-th element.
  task automatic feed(input int r, input logic [35:0] s, input int cnt, input bit gaps, input bit both);
    logic [1:0] gm;
    gm = (r == 1) ? 2'b10 : 2'b01;
    for (int k = 0; k < cnt; k++) begin
      if (gaps) begin
        in_valid = both ? ~gm : 2'b00;
        in_data0 = 4'hE; in_data1 = 4'hE;
        @(negedge clk);
        chk("in_ready_gap", 36'(o_in_ready), 36'(gm));
        tick();
      end
      in_valid = both ? 2'b11 : gm;
      in_data0 = (r == 0) ? s[4*k +: 4] : 4'hE;
      in_data1 = (r == 1) ? s[4*k +: 4] : 4'hE;
      @(negedge clk);
      chk("in_ready", 36'(o_in_ready), 36'(gm));
      chk("grant",    36'(o_grant),    36'(gm));
      tick();
    end
    in_valid = 2'b00;
  endtask

  // Ends at the negedge of the first WRITE cycle; cnt = PROCESS cycles seen.
  task automatic wait_write(input logic [35:0] s, output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!o_valid && cnt < 40) begin
      chk("proc_in_ready", 36'(o_in_ready), 36'd0);
      chk("proc_srt_in",   o_srt_in,        s);
      chk("proc_busy",     36'(o_busy),     36'd1);
      @(posedge clk); #1; cnt++;
      @(negedge clk);
    end
    chk("enter_write", 36'(o_valid), 36'd1);
  endtask

  // Ends at the negedge of the IDLE cycle following the last handshake.
  task automatic drain(input logic [35:0] e, input logic id, input bit tog);
    int i, g, lasts;
    i = 0; g = 0; lasts = 0;
    while (i < 9 && g < 40) begin
      chk("out_valid", 36'(o_valid), 36'd1);
      chk("out_data",  36'(o_data),  36'(e[4*i +: 4]));
      chk("out_id",    36'(o_id),    36'(id));
      chk("out_last",  36'(o_last),  36'(i == 8));
      if (out_ready) begin
        if (o_last) lasts++;
        i++;
      end
      @(posedge clk); #1; g++;
      if (tog) out_ready = ~out_ready;
      @(negedge clk);
    end
    chk("drain_count", 36'(i),       36'd9);
    chk("last_count",  36'(lasts),   36'd1);
    chk("idle_valid",  36'(o_valid), 36'd0);
    chk("idle_grant",  36'(o_grant), 36'd0);
    chk("idle_busy",   36'(o_busy),  36'd0);
    out_ready = 1'b1;
  endtask

  task automatic do_job(input int r, input logic [35:0] s, input logic [35:0] e, input bit tog,
                        input bit gaps, input bit both, input logic [1:0] req_after, input int exp_n);
    int pc;
    feed(r, s, 9, gaps, both);
    req = req_after;
    out_ready = 1'b1;
    wait_write(s, pc);
    chk("proc_cycles", 36'(pc), 36'(exp_n));
    drain(e, (r == 1), tog);
  endtask

  initial begin
    checks = 0; errors = 0; sel = 1'b0;
    rst1 = 1'b1; rst3 = 1'b1;
    req = 2'b00; in_valid = 2'b00; in_data0 = 4'h0; in_data1 = 4'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset("reset1");
    tick();
    rst1 = 1'b0;

    // Single job, latency and ordering
    req = 2'b01; t0 = cyc;
    @(negedge clk);
    chk("t1_idle_grant", 36'(o_grant), 36'd0);
    chk("t1_idle_busy",  36'(o_busy),  36'd0);
    tick();
    feed(0, 36'h4281F0739, 9, 1'b0, 1'b0);
    req = 2'b00;
    wait_write(36'h4281F0739, n);
    chk("t1_proc_cycles", 36'(n), 36'd1);
    chk("t1_latency", 36'(cyc - t0), 36'd11);
    drain(36'hF98743210, 1'b0, 1'b0);

    // Contention from reset: order 0,1,0,1
    tick(); rst1 = 1'b1;
    tick(); rst1 = 1'b0;
    req = 2'b11;
    tick();
    do_job(0, 36'h691E3C055, 36'hEC9655310, 1'b0, 1'b0, 1'b1, 2'b11, 1);
    tick();
    do_job(1, 36'h789ABCDEF, 36'hFEDCBA987, 1'b0, 1'b0, 1'b1, 2'b11, 1);
    tick();
    do_job(0, 36'h0F0F0F0F0, 36'hFFFF00000, 1'b0, 1'b0, 1'b1, 2'b11, 1);
    tick();
    do_job(1, 36'h987654321, 36'h987654321, 1'b0, 1'b0, 1'b1, 2'b00, 1);

    // Backpressure with out_ready toggling
    tick();
    req = 2'b01;
    tick();
    do_job(0, 36'h562951413, 36'h965543211, 1'b1, 1'b0, 1'b0, 2'b00, 1);

    // Abort: requester 1 (priority after a requester-0 job) drops after 4 elements
    tick();
    req = 2'b11;
    tick();
    feed(1, 36'h888888888, 4, 1'b0, 1'b0);
    req = 2'b01; in_valid = 2'b10; in_data1 = 4'h8;
    @(negedge clk);
    chk("abort_grant", 36'(o_grant), 36'd2);
    tick();
    in_valid = 2'b00;
    @(negedge clk);
    chk("abort_valid", 36'(o_valid), 36'd0);
    chk("abort_grant_clr", 36'(o_grant), 36'd0);
    chk("abort_busy", 36'(o_busy), 36'd0);
    tick();
    do_job(0, 36'h281828172, 36'h888722211, 1'b0, 1'b0, 1'b0, 2'b00, 1);

    // Reset in the middle of WRITE at idx 5
    tick();
    req = 2'b10;
    tick();
    feed(1, 36'h4D17C360A, 9, 1'b0, 1'b0);
    req = 2'b00; out_ready = 1'b1;
    wait_write(36'h4D17C360A, n);
    for (int i = 0; i < 5; i++) begin
      chk("mw_out_data", 36'(o_data), 36'((36'hDCA764310 >> (4*i)) & 36'hF));
      tick();
      @(negedge clk);
    end
    chk("mw_idx5_data", 36'(o_data), 36'd7);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    @(negedge clk);
    chk_reset("mid_write");
    tick();
    req = 2'b01;
    tick();
    do_job(0, 36'hD6F40922B, 36'hFDB964220, 1'b0, 1'b0, 1'b0, 2'b00, 1);

    // SORT_LAT=3 instance: gaps in valid, ungranted requester streaming junk
    tick();
    rst1 = 1'b1; rst3 = 1'b0; sel = 1'b1;
    @(negedge clk);
    chk_reset("reset3");
    req = 2'b10;
    tick();
    do_job(1, 36'hA3D50B2E7, 36'hEDBA75320, 1'b0, 1'b1, 1'b1, 2'b00, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
